// File: rtl/pp_st0_ctrl.sv
// Stage-0 ping-pong buffer sequencer: write addressing for one bank, paired-lane
// read addressing for the other, bank swap, and a latency-matched output valid.
module pp_st0_ctrl #(
    parameter int IN_ADDR_WIDTH  = 10,
    parameter int OUT_ADDR_WIDTH = 13,
    parameter int BANK_NUM       = 8,
    parameter int LATENCY        = 1,
    parameter int FRAME_LINES    = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      st0_sel,
    output logic [IN_ADDR_WIDTH-1:0]  st0_waddr,
    output logic                      st0_wen,
    output logic [OUT_ADDR_WIDTH-1:0] st0_raddr,
    output logic                      st0_ren,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic                      out_sof,
    output logic                      out_eof,
    output logic                      busy
);

    localparam int LANE_W = $clog2(BANK_NUM);
    localparam logic [IN_ADDR_WIDTH-1:0] LAST_LINE = IN_ADDR_WIDTH'(FRAME_LINES - 1);
    localparam logic [LANE_W-1:0]        LAST_LANE = LANE_W'(BANK_NUM - 2);

    logic [IN_ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic                     wr_full_q, wr_full_d;
    logic                     rd_active_q, rd_active_d;
    logic [LANE_W-1:0]        lane_q, lane_d;
    logic [IN_ADDR_WIDTH-1:0] line_q, line_d;
    logic                     sel_q, sel_d;
    logic [LATENCY-1:0]       vld_q, vld_d;
    logic [LATENCY-1:0]       sof_q, sof_d;
    logic [LATENCY-1:0]       eof_q, eof_d;

    logic wr_accept;
    logic rd_issue;
    logic line_last;
    logic lane_last;
    logic swap;

    assign wr_accept = in_valid && !wr_full_q;
    assign rd_issue  = rd_active_q && out_ready;
    assign line_last = (line_q == LAST_LINE);
    assign lane_last = (lane_q == LAST_LANE);
    // Waiting for the pipeline to drain keeps the last read of the old frame from
    // landing after the banks have been flipped underneath it.
    assign swap      = wr_full_q && !rd_active_q && !(|vld_q);

    assign in_ready  = !wr_full_q;
    assign st0_wen   = wr_accept;
    assign st0_waddr = wr_cnt_q;
    assign st0_ren   = rd_issue;
    assign st0_raddr = OUT_ADDR_WIDTH'({lane_q, line_q});
    assign st0_sel   = sel_q;
    assign out_valid = vld_q[LATENCY-1];
    assign out_sof   = sof_q[LATENCY-1];
    assign out_eof   = eof_q[LATENCY-1];
    assign busy      = wr_full_q || rd_active_q || (|vld_q) || (wr_cnt_q != '0);

    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        wr_full_d   = wr_full_q;
        rd_active_d = rd_active_q;
        lane_d      = lane_q;
        line_d      = line_q;
        sel_d       = sel_q;

        if (wr_accept) begin
            if (wr_cnt_q == LAST_LINE) begin
                wr_cnt_d  = '0;
                wr_full_d = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + IN_ADDR_WIDTH'(1);
            end
        end

        // Lanes are read in pairs, so the lane counter walks the even lanes only.
        if (rd_issue) begin
            if (line_last) begin
                line_d = '0;
                if (lane_last) begin
                    lane_d      = '0;
                    rd_active_d = 1'b0;
                end else begin
                    lane_d = lane_q + LANE_W'(2);
                end
            end else begin
                line_d = line_q + IN_ADDR_WIDTH'(1);
            end
        end

        if (swap) begin
            sel_d       = !sel_q;
            wr_full_d   = 1'b0;
            rd_active_d = 1'b1;
            lane_d      = '0;
            line_d      = '0;
        end
    end

    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_pipe
        if (gi == 0) begin : g_head
            assign vld_d[gi] = rd_issue;
            assign sof_d[gi] = rd_issue && (lane_q == '0) && (line_q == '0);
            assign eof_d[gi] = rd_issue && lane_last && line_last;
        end else begin : g_tail
            assign vld_d[gi] = vld_q[gi-1];
            assign sof_d[gi] = sof_q[gi-1];
            assign eof_d[gi] = eof_q[gi-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q    <= '0;
            wr_full_q   <= 1'b0;
            rd_active_q <= 1'b0;
            lane_q      <= '0;
            line_q      <= '0;
            sel_q       <= 1'b0;
            vld_q       <= '0;
            sof_q       <= '0;
            eof_q       <= '0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_full_q   <= wr_full_d;
            rd_active_q <= rd_active_d;
            lane_q      <= lane_d;
            line_q      <= line_d;
            sel_q       <= sel_d;
            vld_q       <= vld_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
        end
    end

endmodule

// File: tb/tb_pp_st0_ctrl.sv
// Bench for pp_st0_ctrl: a small frame (4 lines, latency 2) with a cycle table and a
// read/write scoreboard, plus a full-size frame (1024 lines, latency 1).
module tb_pp_st0_ctrl;

    localparam int A_FL  = 4;
    localparam int A_LAT = 2;
    localparam int A_NB  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A: FRAME_LINES=4, LATENCY=2 ----------------
    logic        rst, in_valid, in_ready, st0_sel, st0_wen, st0_ren, out_ready;
    logic        out_valid, out_sof, out_eof, busy;
    logic [9:0]  st0_waddr;
    logic [12:0] st0_raddr;

    pp_st0_ctrl #(
        .IN_ADDR_WIDTH(10), .OUT_ADDR_WIDTH(13), .BANK_NUM(A_NB),
        .LATENCY(A_LAT), .FRAME_LINES(A_FL)
    ) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .st0_sel(st0_sel), .st0_waddr(st0_waddr), .st0_wen(st0_wen),
        .st0_raddr(st0_raddr), .st0_ren(st0_ren), .out_ready(out_ready),
        .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof), .busy(busy)
    );

    // ---------------- DUT B: FRAME_LINES=1024, LATENCY=1 ----------------
    logic        b_rst, b_in_valid, b_in_ready, b_sel, b_wen, b_ren, b_out_ready;
    logic        b_ov, b_sof, b_eof, b_busy;
    logic [9:0]  b_waddr;
    logic [12:0] b_raddr;

    pp_st0_ctrl #(
        .IN_ADDR_WIDTH(10), .OUT_ADDR_WIDTH(13), .BANK_NUM(8),
        .LATENCY(1), .FRAME_LINES(1024)
    ) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .st0_sel(b_sel), .st0_waddr(b_waddr), .st0_wen(b_wen),
        .st0_raddr(b_raddr), .st0_ren(b_ren), .out_ready(b_out_ready),
        .out_valid(b_ov), .out_sof(b_sof), .out_eof(b_eof), .busy(b_busy)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- scoreboard for DUT A ----------------
    typedef struct {
        logic sof;
        logic eof;
        int   due;
    } exp_t;

    exp_t sb_q[$];
    int   w_exp = 0;
    int   r_k   = 0;

    always @(negedge clk) begin : sb
        exp_t it;
        int   er;
        if (rst) begin
            sb_q.delete();
            w_exp <= 0;
            r_k   <= 0;
        end else begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("ov_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    it = sb_q.pop_front();
                    chk("ov_time", cyc, it.due);
                    chk("ov_sof", 32'(out_sof), 32'(it.sof));
                    chk("ov_eof", 32'(out_eof), 32'(it.eof));
                end
            end
            if (st0_wen) begin
                chk("sb_waddr", 32'(st0_waddr), w_exp);
                chk("wen_gated", 32'(in_ready), 32'd1);
                w_exp <= (w_exp + 1) % A_FL;
            end
            if (st0_ren) begin
                er = ((r_k / A_FL) * 2) * 1024 + (r_k % A_FL);
                chk("sb_raddr", 32'(st0_raddr), er);
                it.sof = (r_k == 0);
                it.eof = (r_k == A_FL * A_NB / 2 - 1);
                it.due = cyc + A_LAT;
                sb_q.push_back(it);
                r_k <= (r_k + 1) % (A_FL * A_NB / 2);
            end
        end
    end

    // ---------------- cycle table for the first streaming frames ----------------
    typedef struct {
        int cyc;
        int iv, ordy;
        int wen, waddr, irdy, sel, ren, raddr, ov, sof, eof, busy;
    } row_t;

    localparam int NROWS = 12;
    row_t rows[NROWS];

    task automatic check_row(input row_t r);
        string p;
        p = $sformatf("c%0d", r.cyc);
        chk({p, "_wen"}, 32'(st0_wen), r.wen);
        if (r.wen != 0) chk({p, "_waddr"}, 32'(st0_waddr), r.waddr);
        chk({p, "_in_ready"}, 32'(in_ready), r.irdy);
        chk({p, "_sel"}, 32'(st0_sel), r.sel);
        chk({p, "_ren"}, 32'(st0_ren), r.ren);
        if (r.ren != 0) chk({p, "_raddr"}, 32'(st0_raddr), r.raddr);
        chk({p, "_out_valid"}, 32'(out_valid), r.ov);
        chk({p, "_sof"}, 32'(out_sof), r.sof);
        chk({p, "_eof"}, 32'(out_eof), r.eof);
        chk({p, "_busy"}, 32'(busy), r.busy);
        $display("row cycle %0d checked", r.cyc);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ri, n;
        int wcnt, rcnt, ocnt, sofc, eofc;
        logic [9:0]  last_wa;
        logic [12:0] last_ra;

        //            cyc iv ordy wen wa irdy sel ren raddr ov sof eof busy
        rows[0]  = '{  0, 1, 1,  1, 0, 1, 0, 0,    0, 0, 0, 0, 0};
        rows[1]  = '{  3, 1, 1,  1, 3, 1, 0, 0,    0, 0, 0, 0, 1};
        rows[2]  = '{  4, 1, 1,  0, 0, 0, 0, 0,    0, 0, 0, 0, 1};
        rows[3]  = '{  5, 1, 1,  1, 0, 1, 1, 1,    0, 0, 0, 0, 1};
        rows[4]  = '{  7, 1, 1,  1, 2, 1, 1, 1,    2, 1, 1, 0, 1};
        rows[5]  = '{  8, 1, 1,  1, 3, 1, 1, 1,    3, 1, 0, 0, 1};
        rows[6]  = '{  9, 1, 1,  0, 0, 0, 1, 1, 2048, 1, 0, 0, 1};
        rows[7]  = '{ 20, 1, 1,  0, 0, 0, 1, 1, 6147, 1, 0, 0, 1};
        rows[8]  = '{ 21, 1, 1,  0, 0, 0, 1, 0,    0, 1, 0, 0, 1};
        rows[9]  = '{ 22, 1, 1,  0, 0, 0, 1, 0,    0, 1, 0, 1, 1};
        rows[10] = '{ 23, 1, 1,  0, 0, 0, 1, 0,    0, 0, 0, 0, 1};
        rows[11] = '{ 24, 1, 1,  1, 0, 1, 0, 1,    0, 0, 0, 0, 1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        b_rst = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming from cycle 0: fill, swap, paired-lane reads, second frame into bank1
        ri = 0;
        for (int c = 0; c <= 24; c++) begin
            in_valid  = rows[ri].iv[0];
            out_ready = rows[ri].ordy[0];
            @(negedge clk);
            if (rows[ri].cyc == c) begin
                check_row(rows[ri]);
                if (ri < NROWS - 1) ri++;
            end
            tick;
        end

        // out_ready toggling while frame 2 is read
        for (int i = 0; i < 40; i++) begin
            in_valid  = (i < 3);
            out_ready = (i % 2 == 0);
            @(negedge clk);
            if (i < 26) chk("ren_follows_out_ready", 32'(st0_ren), 32'(out_ready));
            tick;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while (busy && n < 300) begin tick; n++; end
        chk("drain1_busy", 32'(busy), 32'd0);
        chk("drain1_sel", 32'(st0_sel), 32'd1);
        chk("drain1_sb_empty", sb_q.size(), 32'd0);
        $display("streaming and out_ready toggling done");

        // Fill stalls after 2 lines
        in_valid = 1'b1;
        @(negedge clk); chk("stall_waddr0", 32'(st0_waddr), 32'd0); tick;
        @(negedge clk); chk("stall_waddr1", 32'(st0_waddr), 32'd1); tick;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_busy", 32'(busy), 32'd1);
            chk("stall_wen", 32'(st0_wen), 32'd0);
            chk("stall_in_ready", 32'(in_ready), 32'd1);
            chk("stall_sel", 32'(st0_sel), 32'd1);
            chk("stall_ren", 32'(st0_ren), 32'd0);
            tick;
        end
        in_valid = 1'b1;
        @(negedge clk);
        chk("resume_wen", 32'(st0_wen), 32'd1);
        chk("resume_waddr", 32'(st0_waddr), 32'd2);
        tick;
        @(negedge clk); chk("resume_waddr3", 32'(st0_waddr), 32'd3); tick;
        in_valid = 1'b0;
        tick;
        @(negedge clk);
        chk("swap2_sel", 32'(st0_sel), 32'd0);
        chk("swap2_ren", 32'(st0_ren), 32'd1);
        repeat (5) tick;
        $display("mid-fill stall done");

        // Reset in the middle of reads
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ren", 32'(st0_ren), 32'd0);
        chk("rst_wen", 32'(st0_wen), 32'd0);
        chk("rst_sel", 32'(st0_sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("rst_ov", 32'(out_valid), 32'd0);
            chk("rst_sof", 32'(out_sof), 32'd0);
            chk("rst_eof", 32'(out_eof), 32'd0);
            tick;
            @(negedge clk);
        end
        tick;
        in_valid = 1'b1;
        @(negedge clk);
        chk("refill_wen", 32'(st0_wen), 32'd1);
        chk("refill_waddr", 32'(st0_waddr), 32'd0);
        tick;
        repeat (3) tick;
        in_valid = 1'b0;
        n = 0;
        while (busy && n < 300) begin tick; n++; end
        chk("drain2_busy", 32'(busy), 32'd0);
        chk("drain2_sel", 32'(st0_sel), 32'd1);
        chk("drain2_sb_empty", sb_q.size(), 32'd0);
        $display("reset during reads done");

        // Full-size frame on DUT B
        b_rst = 1'b0;
        wcnt = 0; rcnt = 0; ocnt = 0; sofc = 0; eofc = 0;
        last_wa = '0; last_ra = '0;
        for (int i = 0; i < 8000; i++) begin
            b_in_valid = (i < 1024);
            @(negedge clk);
            if (b_wen) begin wcnt++; last_wa = b_waddr; end
            if (b_ren) begin rcnt++; last_ra = b_raddr; end
            if (b_ov) ocnt++;
            if (b_sof) sofc++;
            if (b_eof) eofc++;
            if (i == 1024) chk("b_full_in_ready", 32'(b_in_ready), 32'd0);
            tick;
            if (i > 1024 && !b_busy) break;
        end
        chk("b_idle", 32'(b_busy), 32'd0);
        chk("b_writes", wcnt, 32'd1024);
        chk("b_last_waddr", 32'(last_wa), 32'd1023);
        chk("b_reads", rcnt, 32'd4096);
        chk("b_last_raddr", 32'(last_ra), 32'd7167);
        chk("b_out_valid_pulses", ocnt, 32'd4096);
        chk("b_sof_count", sofc, 32'd1);
        chk("b_eof_count", eofc, 32'd1);
        chk("b_sel", 32'(b_sel), 32'd1);
        b_in_valid = 1'b1;
        @(negedge clk);
        chk("b_wrap_wen", 32'(b_wen), 32'd1);
        chk("b_wrap_waddr", 32'(b_waddr), 32'd0);
        tick;
        b_in_valid = 1'b0;
        $display("full-size frame done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/pp_st0_ctrl.md
Name: pp_st0_ctrl

Overview:
- Sequencing controller for the stage-0 ping-pong buffer of the encoder.
- Write side: accepts wide input lines from upstream over a valid/ready handshake and generates the write address and write enable for the current write bank.
- Read side: generates the per-lane read addresses and read enable for the opposite bank, and a delayed output-valid with frame markers for the downstream consumer.
- Owns the bank select and swaps the banks only when the write bank is full and the read bank is fully drained. Write data and read data bypass this block and connect directly to the buffer.

Parameters:
IN_ADDR_WIDTH, 10, buffer line address width.
OUT_ADDR_WIDTH, 13, read address width; the upper log2(BANK_NUM) bits are the lane, the lower IN_ADDR_WIDTH bits are the line.
BANK_NUM, 8, lanes per line; must be an even power of 2.
LATENCY, 1, buffer read latency in cycles, >=1.
FRAME_LINES, 1024, lines per frame; 2 <= FRAME_LINES <= 2^IN_ADDR_WIDTH.

Ports:
clk  in  1  clock; the block has one clock.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  upstream line valid.
in_ready  out  1  controller can accept a line.
st0_sel  out  1  bank select; 0 = write bank0 and read bank1, 1 = the reverse.
st0_waddr  out  IN_ADDR_WIDTH  write line address.
st0_wen  out  1  write enable.
st0_raddr  out  OUT_ADDR_WIDTH  read address, {lane, line}.
st0_ren  out  1  read enable.
out_ready  in  1  downstream permits issue of a read this cycle.
out_valid  out  1  st0_re/st0_im valid at the buffer output this cycle.
out_sof  out  1  qualifies the first word of a frame.
out_eof  out  1  qualifies the last word of a frame.
busy  out  1  a frame is in the buffer, being read, or in flight.

Behaviour:
- Reset values: all outputs 0; st0_sel=0; write count 0; wr_full=0; rd_active=0; read counters 0; valid pipeline cleared. Reset mid-frame discards all in-flight reads; out_valid goes 0 in the next cycle.
- Write side:
  - in_ready = !wr_full, combinational from registers.
  - On accept (in_valid && in_ready), st0_wen=1 in the same cycle with st0_waddr=wr_cnt, and wr_cnt increments.
  - When the accepted line has wr_cnt==FRAME_LINES-1: wr_cnt wraps to 0 and wr_full is set at the next edge.
  - st0_wen is never asserted while wr_full=1.
- Read address order, per frame:
  - lane steps 0,2,4,...,BANK_NUM-2 (outer loop); line steps 0..FRAME_LINES-1 (inner loop).
  - st0_raddr = {lane, line}.
  - Reads per frame = FRAME_LINES*BANK_NUM/2.
- Read issue:
  - st0_ren = rd_active && out_ready; counters advance only on issue.
  - On issue of the final read (lane=BANK_NUM-2, line=FRAME_LINES-1), rd_active clears at the next edge and the counters return to 0.
- Output valid: out_valid, out_sof and out_eof are st0_ren, first-issue and last-issue delayed by exactly LATENCY cycles through a shift pipeline. out_ready has no effect on reads already issued.
- Bank swap:
  - Condition: wr_full && !rd_active && read pipeline empty.
  - At that edge: st0_sel toggles, wr_full clears, rd_active sets, read counters reset.
  - The swap occurs in the first cycle the condition holds, independent of in_valid and out_ready.
  - No writes occur in the swap cycle (wr_full=1).
- First frame after reset: the read side starts with rd_active=0, so the swap follows fill immediately. Bank1 is never read before it is written.
- Simultaneous events:
  - Final write accept and final read issue in the same cycle: no swap that cycle; the swap happens once the pipeline empties.
  - Write side stalled while read is active: in_ready stays 0 until the swap.
- busy = wr_full || rd_active || any pipeline stage valid || wr_cnt!=0.

Test Plan:
- Params FRAME_LINES=4, BANK_NUM=8, LATENCY=2, out_ready=1, in_valid=1 from cycle 0 after reset.
  - Required: st0_wen in cycles 0-3 with waddr 0,1,2,3 and st0_sel=0; in_ready=0 in cycle 4; st0_sel=1 from cycle 5.
  - Required: st0_ren in cycles 5-20 with raddr lane 0 lines 0-3, then lanes 2, 4, 6; out_valid in cycles 7-22, out_sof in cycle 7, out_eof in cycle 22.
- Continuous streaming with the same params:
  - Required: the second frame writes bank1 (waddr 0-3 in cycles 5-8).
  - Required: the next swap occurs only after out_valid of the first frame's eof has retired (pipeline empty), then st0_sel=0 and the reads target bank1.
- out_ready toggling 1,0,1,0 during reads:
  - Required: st0_ren follows out_ready; the address sequence has no gaps or repeats.
  - Required: out_valid pattern equals the st0_ren pattern shifted by 2.
- in_valid deasserted mid-fill after 2 lines:
  - Required: wr_cnt holds at 2, no swap, busy=1; the fill resumes at waddr 2.
- rst asserted during reads of frame 1:
  - Required: next cycle all outputs 0 and st0_sel=0; out_valid stays 0 through the stale pipeline; a refill restarts at waddr 0.
- FRAME_LINES=1024, LATENCY=1:
  - Required: wr_cnt wraps 1023->0; the final raddr is {6, 1023}; 4096 out_valid pulses per frame.
